// File: rtl/wb_stim_responder.sv
// Wishbone slave stimulus responder for the a25_core bench. It serves queued
// instruction lines and load words, inserts wait states, captures write cycles
// and releases system-ready after reset.
// Latency: an ack or err arrives ACK_DELAY+1 cycles after the IDLE sample.
// Backpressure: there is none toward the core. Host pushes into a full FIFO are dropped.
// Ports:
//   i_clk/i_rst                    clock, synchronous active-high reset
//   i_inst_push/i_inst_line        instruction-line FIFO write (128b)
//   i_data_push/i_data_word        load-data FIFO write (32b)
//   o_inst_*/o_data_*              FIFO full flags and occupancy
//   i_wb_*/o_wb_*                  Wishbone slave side facing the core
//   o_system_rdy                   core release, RDY_DELAY cycles after reset
//   o_cap_*                        last captured write, with a one-cycle valid pulse
//   o_underflow                    sticky flag for a data read from an empty FIFO

// Generic synchronous FIFO. It has a combinational head and occupancy count.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: a push while full is dropped, unless a pop happens in the same cycle.
module wb_stim_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign do_push  = push & (~full | do_pop);
  assign head_dat = mem[rd_ptr];
  assign count    = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // The pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

module wb_stim_responder #(
  parameter int             IFIFO_DEPTH = 8,
  parameter int             DFIFO_DEPTH = 8,
  parameter logic [31:0]    DATA_BASE   = 32'h0000_8000,
  parameter logic [127:0]   NOP_LINE    = 128'hF0801003F0801003F0801003F0801003,
  parameter int             ACK_DELAY   = 2,
  parameter int             RDY_DELAY   = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_inst_push,
  input  logic [127:0]                   i_inst_line,
  input  logic                           i_data_push,
  input  logic [31:0]                    i_data_word,
  output logic                           o_inst_full,
  output logic                           o_data_full,
  output logic [$clog2(IFIFO_DEPTH):0]   o_inst_count,
  output logic [$clog2(DFIFO_DEPTH):0]   o_data_count,
  input  logic [31:0]                    i_wb_adr,
  input  logic [15:0]                    i_wb_sel,
  input  logic                           i_wb_we,
  input  logic                           i_wb_cyc,
  input  logic                           i_wb_stb,
  input  logic [127:0]                   i_wb_dat,
  output logic [127:0]                   o_wb_dat,
  output logic                           o_wb_ack,
  output logic                           o_wb_err,
  output logic                           o_system_rdy,
  output logic                           o_cap_valid,
  output logic [31:0]                    o_cap_adr,
  output logic [15:0]                    o_cap_sel,
  output logic [127:0]                   o_cap_dat,
  output logic                           o_underflow
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam int RW = $clog2(RDY_DELAY + 1) + 1;

  state_t         state_q, state_d;
  logic [3:0]     wait_q, wait_d;
  logic           latch;
  logic [31:0]    adr_q;
  logic [15:0]    sel_q;
  logic           we_q;
  logic [127:0]   dat_q;
  logic [RW-1:0]  rdy_cnt_q;

  logic           inst_pop, data_pop, inst_empty, data_empty;
  logic [127:0]   inst_head;
  logic [31:0]    data_head;
  logic           rd_ack_cycle, data_sel, err;
  logic           enter_ack, src_we;

  wb_stim_fifo #(.WIDTH(128), .DEPTH(IFIFO_DEPTH)) u_inst_fifo (
    .clk(i_clk), .rst(i_rst), .push(i_inst_push), .push_dat(i_inst_line),
    .pop(inst_pop), .head_dat(inst_head), .count(o_inst_count),
    .full(o_inst_full), .empty(inst_empty)
  );

  wb_stim_fifo #(.WIDTH(32), .DEPTH(DFIFO_DEPTH)) u_data_fifo (
    .clk(i_clk), .rst(i_rst), .push(i_data_push), .push_dat(i_data_word),
    .pop(data_pop), .head_dat(data_head), .count(o_data_count),
    .full(o_data_full), .empty(data_empty)
  );

  // Ready counter: it saturates at RDY_DELAY. A zero delay is ready as soon as
  // reset drops, so that case is gated by i_rst directly.
  always_ff @(posedge i_clk) begin
    if (i_rst)                              rdy_cnt_q <= '0;
    else if (rdy_cnt_q != RW'(RDY_DELAY))   rdy_cnt_q <= rdy_cnt_q + 1'b1;
  end
  assign o_system_rdy = (RDY_DELAY == 0) ? ~i_rst : (rdy_cnt_q == RW'(RDY_DELAY));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    latch        = 1'b0;
    o_wb_dat     = '0;
    inst_pop     = 1'b0;
    data_pop     = 1'b0;
    err          = 1'b0;
    rd_ack_cycle = (state_q == S_ACK) & ~we_q;
    data_sel     = (adr_q >= DATA_BASE);
    case (state_q)
      S_IDLE: begin
        if (o_system_rdy & i_wb_cyc & i_wb_stb) begin
          latch   = 1'b1;
          wait_d  = 4'(ACK_DELAY);
          state_d = (ACK_DELAY == 0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        wait_d = wait_q - 1'b1;
        if (wait_q <= 4'd1) state_d = S_ACK;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // The read source and its empty check are resolved in the ACK cycle. A push
    // that lands during WAIT is therefore served.
    if (rd_ack_cycle) begin
      if (!data_sel) begin
        inst_pop = ~inst_empty;
        o_wb_dat = inst_empty ? NOP_LINE : inst_head;
      end else if (!data_empty) begin
        data_pop = 1'b1;
        o_wb_dat = {4{data_head}};
      end else begin
        err = 1'b1;
      end
    end
  end

  assign o_wb_err    = err;
  assign o_wb_ack    = (state_q == S_ACK) & ~err;
  assign o_cap_valid = (state_q == S_ACK) & we_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      adr_q <= '0;
      sel_q <= '0;
      we_q  <= 1'b0;
      dat_q <= '0;
    end else if (latch) begin
      adr_q <= i_wb_adr;
      sel_q <= i_wb_sel;
      we_q  <= i_wb_we;
      dat_q <= i_wb_dat;
    end
  end

  // Capture registers load on the edge into ACK, so they are already valid
  // alongside o_cap_valid. With zero wait states that edge is also the IDLE
  // sample, so the live bus values are used instead of the latched ones.
  assign enter_ack = (state_d == S_ACK) & (state_q != S_ACK);
  assign src_we    = latch ? i_wb_we : we_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cap_adr   <= '0;
      o_cap_sel   <= '0;
      o_cap_dat   <= '0;
      o_underflow <= 1'b0;
    end else begin
      if (enter_ack & src_we) begin
        o_cap_adr <= latch ? i_wb_adr : adr_q;
        o_cap_sel <= latch ? i_wb_sel : sel_q;
        o_cap_dat <= latch ? i_wb_dat : dat_q;
      end
      if (err) o_underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_stim_responder.sv
// Directed self-checking bench for wb_stim_responder with the default parameters
// (ACK_DELAY=2, RDY_DELAY=4, FIFO depths of 8). It uses a table of bus transfers
// plus hand sequences for the reset, FIFO-full and same-cycle push/pop cases.
module tb_wb_stim_responder;
  localparam logic [127:0] NOP   = 128'hF0801003F0801003F0801003F0801003;
  localparam logic [127:0] LINE1 = 128'hF0801003F0801003F0801003E0801002;

  logic         clk = 1'b0;
  logic         i_rst, i_inst_push, i_data_push;
  logic [127:0] i_inst_line;
  logic [31:0]  i_data_word;
  logic         o_inst_full, o_data_full;
  logic [3:0]   o_inst_count, o_data_count;
  logic [31:0]  i_wb_adr;
  logic [15:0]  i_wb_sel;
  logic         i_wb_we, i_wb_cyc, i_wb_stb;
  logic [127:0] i_wb_dat, o_wb_dat;
  logic         o_wb_ack, o_wb_err, o_system_rdy, o_cap_valid, o_underflow;
  logic [31:0]  o_cap_adr;
  logic [15:0]  o_cap_sel;
  logic [127:0] o_cap_dat;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  wb_stim_responder dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_inst_push(i_inst_push), .i_inst_line(i_inst_line),
    .i_data_push(i_data_push), .i_data_word(i_data_word),
    .o_inst_full(o_inst_full), .o_data_full(o_data_full),
    .o_inst_count(o_inst_count), .o_data_count(o_data_count),
    .i_wb_adr(i_wb_adr), .i_wb_sel(i_wb_sel), .i_wb_we(i_wb_we),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_dat(i_wb_dat),
    .o_wb_dat(o_wb_dat), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
    .o_system_rdy(o_system_rdy), .o_cap_valid(o_cap_valid),
    .o_cap_adr(o_cap_adr), .o_cap_sel(o_cap_sel), .o_cap_dat(o_cap_dat),
    .o_underflow(o_underflow)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All tasks assume they start 1ns after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_inst(input logic [127:0] l);
    i_inst_push = 1'b1;
    i_inst_line = l;
    tick();
    i_inst_push = 1'b0;
  endtask

  task automatic push_data(input logic [31:0] w);
    i_data_push = 1'b1;
    i_data_word = w;
    tick();
    i_data_push = 1'b0;
  endtask

  // Runs one bus transfer and returns what was seen in the ack/err cycle.
  // The optional host push lands in that same cycle.
  task automatic bus(input logic we, input logic [31:0] adr, input logic [15:0] sel,
                     input logic [127:0] wdat, input logic push_at_ack,
                     input logic [127:0] push_line,
                     output logic ack, output logic err, output logic cv,
                     output logic [127:0] dat, output int lat);
    i_wb_we = we; i_wb_adr = adr; i_wb_sel = sel; i_wb_dat = wdat;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!o_wb_ack && !o_wb_err && lat < 20);
    ack = o_wb_ack; err = o_wb_err; cv = o_cap_valid; dat = o_wb_dat;
    check("ack_err_exclusive", {127'b0, o_wb_ack & o_wb_err}, 128'd0);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    if (push_at_ack) begin
      i_inst_push = 1'b1;
      i_inst_line = push_line;
    end
    tick();
    i_inst_push = 1'b0;
    check("ack_single_cycle", {126'b0, o_wb_ack, o_wb_err}, 128'd0);
    check("cap_valid_single", {127'b0, o_cap_valid}, 128'd0);
  endtask

  typedef struct {
    logic         we;
    logic [31:0]  adr;
    logic [15:0]  sel;
    logic [127:0] wdat;
    logic         exp_ack;
    logic         exp_err;
    logic [127:0] exp_dat;
    int           exp_icnt;
    int           exp_dcnt;
    logic         exp_uf;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic ack, err, cv;
    logic [127:0] dat;
    int lat;
    logic seen;

    vecs[0] = '{1'b0, 32'h0000_0000, 16'hFFFF, 128'd0, 1'b1, 1'b0, LINE1, 0, 2, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0010, 16'hFFFF, 128'd0, 1'b1, 1'b0, NOP, 0, 2, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_8000, 16'hFFFF, 128'd0, 1'b1, 1'b0, {4{32'h5}}, 0, 1, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_8000, 16'hFFFF, 128'd0, 1'b1, 1'b0, {4{32'h1}}, 0, 0, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_8000, 16'hFFFF, 128'd0, 1'b0, 1'b1, 128'd0, 0, 0, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_8004, 16'h00F0, 128'h0000_0000_0000_0000_0000_0006_0000_0000,
                1'b1, 1'b0, 128'd0, 0, 0, 1'b1};
    vecs[6] = '{1'b0, 32'h0000_7FFC, 16'hFFFF, 128'd0, 1'b1, 1'b0, NOP, 0, 0, 1'b1};

    i_rst = 1'b1; i_inst_push = 1'b0; i_data_push = 1'b0;
    i_inst_line = '0; i_data_word = '0;
    i_wb_adr = '0; i_wb_sel = '0; i_wb_we = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    i_wb_dat = '0;

    // Check reset values, then release reset with a read already pending.
    repeat (3) tick();
    check("rst_outputs", {121'b0, o_wb_ack, o_wb_err, o_system_rdy, o_cap_valid,
                          o_underflow, o_inst_full, o_data_full}, 128'd0);
    check("rst_wb_dat", o_wb_dat, 128'd0);
    check("rst_cap", {o_cap_dat[95:0], o_cap_adr}, 128'd0);
    check("rst_cap_sel", {112'b0, o_cap_sel}, 128'd0);
    check("rst_counts", {120'b0, o_inst_count, o_data_count}, 128'd0);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    tick();
    i_rst = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("rdy_cycle%0d", c), {127'b0, o_system_rdy}, {127'b0, c == 5});
      check($sformatf("no_ack_before_rdy%0d", c), {127'b0, o_wb_ack}, 128'd0);
      if (c < 5) tick();
    end
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!o_wb_ack && lat < 20);
    check("first_ack_latency", 128'(lat), 128'd3);
    check("first_ack_nop", o_wb_dat, NOP);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    tick();

    // Preload the FIFOs, then run the transfer table.
    push_inst(LINE1);
    push_data(32'h0000_0005);
    push_data(32'h0000_0001);
    check("preload_icnt", 128'(o_inst_count), 128'd1);
    check("preload_dcnt", 128'(o_data_count), 128'd2);

    for (int v = 0; v < 7; v++) begin
      bus(vecs[v].we, vecs[v].adr, vecs[v].sel, vecs[v].wdat, 1'b0, 128'd0,
          ack, err, cv, dat, lat);
      check($sformatf("v%0d_latency", v), 128'(lat), 128'd3);
      check($sformatf("v%0d_ack", v), {127'b0, ack}, {127'b0, vecs[v].exp_ack});
      check($sformatf("v%0d_err", v), {127'b0, err}, {127'b0, vecs[v].exp_err});
      check($sformatf("v%0d_dat", v), dat, vecs[v].exp_dat);
      check($sformatf("v%0d_cap_valid", v), {127'b0, cv}, {127'b0, vecs[v].we});
      check($sformatf("v%0d_icnt", v), 128'(o_inst_count), 128'(vecs[v].exp_icnt));
      check($sformatf("v%0d_dcnt", v), 128'(o_data_count), 128'(vecs[v].exp_dcnt));
      check($sformatf("v%0d_underflow", v), {127'b0, o_underflow}, {127'b0, vecs[v].exp_uf});
    end
    // The capture from the write in vector 5 must survive the read that followed it.
    check("cap_adr_hold", 128'(o_cap_adr), 128'h8004);
    check("cap_sel_hold", 128'(o_cap_sel), 128'h00F0);
    check("cap_dat_hold", o_cap_dat, 128'h0000_0000_0000_0000_0000_0006_0000_0000);

    // Fill the instruction FIFO, then push a dropped ninth line.
    for (int k = 0; k < 8; k++) push_inst({4{32'hA000_0000 + 32'(k)}});
    check("fill_count", 128'(o_inst_count), 128'd8);
    check("fill_full", {127'b0, o_inst_full}, 128'd1);
    push_inst({4{32'hDEAD_BEEF}});
    check("overflow_count", 128'(o_inst_count), 128'd8);
    check("overflow_full", {127'b0, o_inst_full}, 128'd1);

    // Push and pop in the same cycle while full: the count holds and the head is served.
    bus(1'b0, 32'h0, 16'hFFFF, 128'd0, 1'b1, {4{32'hB0B0_B0B0}}, ack, err, cv, dat, lat);
    check("pushpop_dat", dat, {4{32'hA000_0000}});
    check("pushpop_count", 128'(o_inst_count), 128'd8);
    // Drain the FIFO. Order must be A1..A7 then the line pushed at ACK, with no DEADBEEF.
    for (int k = 1; k < 9; k++) begin
      bus(1'b0, 32'h0, 16'hFFFF, 128'd0, 1'b0, 128'd0, ack, err, cv, dat, lat);
      check($sformatf("drain%0d", k), dat,
            (k < 8) ? {4{32'hA000_0000 + 32'(k)}} : {4{32'hB0B0_B0B0}});
    end
    check("drained_count", 128'(o_inst_count), 128'd0);

    // Reset during WAIT: the transfer is aborted and both FIFOs are flushed.
    push_inst(LINE1);
    push_data(32'h0000_0009);
    i_wb_we = 1'b0; i_wb_adr = 32'h0; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    tick();
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    check("abort_no_ack", {126'b0, o_wb_ack, o_wb_err}, 128'd0);
    check("abort_counts", {120'b0, o_inst_count, o_data_count}, 128'd0);
    check("abort_rdy_low", {127'b0, o_system_rdy}, 128'd0);
    check("abort_uf_clear", {127'b0, o_underflow}, 128'd0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (o_wb_ack || o_wb_err) seen = 1'b1;
    end
    check("abort_no_late_ack", {127'b0, seen}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/wb_stim_responder.md
Name: wb_stim_responder

Overview:
- Wishbone slave model and sequencer that sits opposite the amber25 core (a25_core) in the GUVM bench.
- Replaces ad-hoc task-driven bus wiggling with queued stimulus:
  - serves 128-bit instruction lines and 32-bit load data from two FIFOs;
  - inserts programmable wait states;
  - captures core write cycles for checking.
- Also generates the core's system-ready release after reset.

Parameters:
- IFIFO_DEPTH, 8: instruction-line FIFO entries (power of 2).
- DFIFO_DEPTH, 8: data-word FIFO entries (power of 2).
- DATA_BASE, 32'h0000_8000: byte address at or above which reads are served from the data FIFO.
- NOP_LINE, 128'hF0801003F0801003F0801003F0801003: line returned when the instruction FIFO is empty.
- ACK_DELAY, 2: wait states between request sample and ack (0..15).
- RDY_DELAY, 4: cycles after reset release before system ready asserts.

Ports:
- i_clk, in, 1: clock.
- i_rst, in, 1: reset, synchronous, active-high.
- i_inst_push, in, 1: push i_inst_line into the instruction FIFO.
- i_inst_line, in, 128: instruction line, four words.
- i_data_push, in, 1: push i_data_word into the data FIFO.
- i_data_word, in, 32: load data word.
- o_inst_full, out, 1: instruction FIFO full.
- o_data_full, out, 1: data FIFO full.
- o_inst_count, out, $clog2(IFIFO_DEPTH)+1: instruction FIFO occupancy.
- o_data_count, out, $clog2(DFIFO_DEPTH)+1: data FIFO occupancy.
- i_wb_adr, in, 32: core address.
- i_wb_sel, in, 16: core byte selects.
- i_wb_we, in, 1: core write enable.
- i_wb_cyc, in, 1: core cycle.
- i_wb_stb, in, 1: core strobe.
- i_wb_dat, in, 128: core write data.
- o_wb_dat, out, 128: read data to the core.
- o_wb_ack, out, 1: transfer acknowledge.
- o_wb_err, out, 1: error acknowledge.
- o_system_rdy, out, 1: system ready to the core.
- o_cap_valid, out, 1: one-cycle pulse when a write is captured.
- o_cap_adr, out, 32: captured write address.
- o_cap_sel, out, 16: captured write byte selects.
- o_cap_dat, out, 128: captured write data.
- o_underflow, out, 1: sticky; set on a data read while the data FIFO is empty.

Behaviour:
- Reset values:
  - o_wb_ack, o_wb_err, o_system_rdy, o_cap_valid and o_underflow are 0.
  - o_wb_dat, o_cap_adr, o_cap_sel and o_cap_dat are 0.
  - Both FIFOs are emptied (counts 0, full flags 0).
  - FSM is in IDLE.
- Reset mid-transfer aborts the transfer with no ack, and flushes both FIFOs.
- Ready counter:
  - Counts from the first cycle with i_rst low.
  - o_system_rdy rises after exactly RDY_DELAY such cycles and stays high until reset.
  - RDY_DELAY=0 gives ready on the first non-reset cycle.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: when o_system_rdy & i_wb_cyc & i_wb_stb, latch adr/we/sel/dat and the wait count.
    - If ACK_DELAY=0, go to ACK; otherwise go to WAIT.
    - Requests while o_system_rdy=0 are ignored.
  - WAIT: decrement the counter; go to ACK on the cycle it reaches 0. Total WAIT cycles = ACK_DELAY.
  - ACK: assert o_wb_ack (or o_wb_err) for exactly one cycle, then return to IDLE.
    - If the core still holds stb next cycle, that cycle is a new request.
- Request-to-ack latency is ACK_DELAY+1 cycles from the IDLE sample.
- Read, address below DATA_BASE:
  - o_wb_dat is the FIFO head line; popped in the ACK cycle.
  - If the FIFO is empty, return NOP_LINE with no pop.
- Read, address at or above DATA_BASE:
  - o_wb_dat is the head word replicated into all four 32-bit lanes; popped in the ACK cycle.
  - If the FIFO is empty, assert o_wb_err instead of ack, set o_underflow, and drive data 0.
- o_wb_dat is valid only during ack/err; it is driven 0 otherwise.
- Write (i_wb_we=1):
  - In the ACK cycle, o_cap_valid=1 and o_cap_adr/sel/dat are updated with the latched values.
  - Captured values hold until the next write.
  - FIFOs are not touched.
- FIFO rules:
  - A push when full is dropped; count and contents are unchanged.
  - A simultaneous push and pop on the same FIFO both take effect: count unchanged, ordering preserved, allowed even when full.
  - Pointers wrap modulo depth.
  - Host push while the FSM is in WAIT is visible to a pending read only if the FIFO was non-empty at ACK. Source selection is made at ACK, not at IDLE.
- o_wb_err and o_wb_ack are never asserted together.

Test Plan:
1. Reset, RDY_DELAY=4: release i_rst -> o_system_rdy=0 for 4 cycles, 1 on the 5th; a stb asserted earlier gets no ack until ready.
2. Push line 128'hF0801003F0801003F0801003E0801002; core read adr 0x0 -> ack exactly 3 cycles after the request sample, o_wb_dat equals the line, o_inst_count 1->0.
3. Empty instruction FIFO, read adr 0x10 -> ack with NOP_LINE, count stays 0, no err.
4. Push data 32'h00000005 then 32'h00000001; two reads at 0x8000 -> 128'h00000005 replicated into all four lanes, then 128'h00000001 replicated; third read -> o_wb_err=1, o_wb_ack=0, o_underflow sticky 1.
5. Core write adr 0x8004, sel 16'h00F0, dat 128'h...0000_0006_0000_0000 -> o_cap_valid single pulse coincident with ack; capture registers match; o_data_count unchanged.
6. Fill the instruction FIFO to 8, push a 9th -> dropped, o_inst_full=1. Then push and read the same cycle -> count stays 8 and the first line is returned. Then assert i_rst during WAIT -> no ack, counts 0.
